// File: rtl/bitwise_logic_pipe_pkg.sv
// Shared definitions for the bitwise logic pipeline: op type and op encodings.
package bitwise_logic_pipe_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_AND  = 3'b000;
  localparam op_t OP_OR   = 3'b001;
  localparam op_t OP_XOR  = 3'b010;
  localparam op_t OP_XNOR = 3'b011;
  localparam op_t OP_NAND = 3'b100;
  localparam op_t OP_NOR  = 3'b101;
  localparam op_t OP_ANDN = 3'b110;
  localparam op_t OP_NOTA = 3'b111;

endpackage

// File: rtl/bitwise_logic_pipe_if.sv
// Operand/result handshake bundle for bitwise_logic_pipe.
interface bitwise_logic_pipe_if #(
  parameter int WIDTH = 64
);

  logic                         in_valid;
  logic                         in_ready;
  logic [WIDTH-1:0]             A;
  logic [WIDTH-1:0]             B;
  bitwise_logic_pipe_pkg::op_t  op;
  logic                         out_valid;
  logic                         out_ready;
  logic [WIDTH-1:0]             out;
  logic                         zero;
  logic                         parity;

  // master supplies operands and consumes results; slave is the pipeline
  modport master (
    output in_valid, A, B, op, out_ready,
    input  in_ready, out_valid, out, zero, parity
  );

  modport slave (
    input  in_valid, A, B, op, out_ready,
    output in_ready, out_valid, out, zero, parity
  );

endinterface

// File: rtl/bitwise_logic_core.sv
// Combinational bitwise operation selected by op; holds no state.
module bitwise_logic_core
  import bitwise_logic_pipe_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_t              op,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_XNOR: result = ~(a ^ b);
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_ANDN: result = a & ~b;
      OP_NOTA: result = ~a;
    endcase
  end

endmodule

// File: rtl/bitwise_logic_pipe.sv
// Two-stage valid/ready pipeline around bitwise_logic_core; S2 carries result
// plus zero/parity flags so the flags always describe the presented result.
module bitwise_logic_pipe
  import bitwise_logic_pipe_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  bitwise_logic_pipe_if.slave  bus
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic             s2_valid;
  logic [WIDTH-1:0] s2_data;
  logic             s2_zero;
  logic             s2_parity;

  logic [WIDTH-1:0] core_result;
  logic             s2_load;
  logic             s1_adv;
  logic             in_ready;
  logic             in_xfer;

  bitwise_logic_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a      (bus.A),
    .b      (bus.B),
    .op     (bus.op),
    .result (core_result)
  );

  // in_ready depends only on stage state and out_ready, never on in_valid
  assign s2_load  = !s2_valid || bus.out_ready;
  assign s1_adv   = s1_valid && s2_load;
  assign in_ready = !s1_valid || s1_adv;
  assign in_xfer  = bus.in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else if (in_xfer) begin
      s1_valid <= 1'b1;
      s1_data  <= core_result;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // flags are computed from S1 and registered alongside the result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_data   <= '0;
      s2_zero   <= 1'b1;
      s2_parity <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data   <= s1_data;
        s2_zero   <= ~|s1_data;
        s2_parity <= ^s1_data;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid;
  assign bus.out       = s2_data;
  assign bus.zero      = s2_zero;
  assign bus.parity    = s2_parity;

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Scoreboard bench for bitwise_logic_pipe at WIDTH 64, 8 and 128.
module tb_bitwise_logic_pipe;

  typedef struct {
    logic [127:0] out;
    logic         zero;
    logic         parity;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         d_in_valid;
  logic         d_out_ready;
  logic [127:0] d_A;
  logic [127:0] d_B;
  logic [2:0]   d_op;
  int           sel = 0;
  int           cur_w = 64;

  logic         obs_in_ready  [3];
  logic         obs_out_valid [3];
  logic         obs_zero      [3];
  logic         obs_parity    [3];
  logic [127:0] obs_out       [3];

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int W = (g == 0) ? 64 : ((g == 1) ? 8 : 128);
      bitwise_logic_pipe_if #(.WIDTH(W)) ifc ();
      assign ifc.in_valid  = d_in_valid && (sel == g);
      assign ifc.A         = d_A[W-1:0];
      assign ifc.B         = d_B[W-1:0];
      assign ifc.op        = d_op;
      assign ifc.out_ready = d_out_ready;
      bitwise_logic_pipe #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
      );
      assign obs_in_ready[g]  = ifc.in_ready;
      assign obs_out_valid[g] = ifc.out_valid;
      assign obs_zero[g]      = ifc.zero;
      assign obs_parity[g]    = ifc.parity;
      assign obs_out[g]       = 128'(ifc.out);
    end
  endgenerate

  logic         c_in_ready, c_out_valid, c_zero, c_parity;
  logic [127:0] c_out;
  assign c_in_ready  = obs_in_ready[sel];
  assign c_out_valid = obs_out_valid[sel];
  assign c_zero      = obs_zero[sel];
  assign c_parity    = obs_parity[sel];
  assign c_out       = obs_out[sel];

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  exp_t ovr;
  bit   use_ovr = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // each op is a 2-input truth table indexed by {a_bit, b_bit}
  function automatic exp_t model(input logic [2:0] o, input logic [127:0] a,
                                 input logic [127:0] b, input int w);
    exp_t       e;
    logic [3:0] tt;
    case (o)
      3'd0: tt = 4'b1000;
      3'd1: tt = 4'b1110;
      3'd2: tt = 4'b0110;
      3'd3: tt = 4'b1001;
      3'd4: tt = 4'b0111;
      3'd5: tt = 4'b0001;
      3'd6: tt = 4'b0100;
      default: tt = 4'b0011;
    endcase
    e.out = '0;
    for (int i = 0; i < w; i++) e.out[i] = tt[{a[i], b[i]}];
    e.zero   = (e.out == 0);
    e.parity = (($countones(e.out) % 2) == 1);
    return e;
  endfunction

  task automatic drive(input bit v, input logic [2:0] o, input logic [127:0] a,
                       input logic [127:0] b, input bit ordy, output bit acc);
    @(negedge clk);
    d_in_valid  = v;
    d_op        = o;
    d_A         = a;
    d_B         = b;
    d_out_ready = ordy;
    #1;
    acc = v && c_in_ready;
    if (acc) begin
      if (use_ovr) sb.push_back(ovr);
      else sb.push_back(model(o, a, b, cur_w));
    end
    use_ovr = 0;
  endtask

  task automatic idle(input bit ordy);
    bit acc;
    drive(1'b0, 3'd0, '0, '0, ordy, acc);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || c_out_valid) && n < 60) begin
      idle(1'b1);
      n++;
    end
    chk("drain_empty", 128'(sb.size()), 128'd0);
  endtask

  // monitor: pops on every output transfer and checks stability under backpressure
  initial begin
    bit           prev_hold = 0;
    logic [127:0] prev_out = '0;
    logic         prev_z = 1'b0, prev_p = 1'b0;
    exp_t         e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_hold = 0;
      end else begin
        if (prev_hold) begin
          chk("hold_out", c_out, prev_out);
          chk("hold_flags", {c_out_valid, c_zero, c_parity}, {1'b1, prev_z, prev_p});
        end
        if (c_out_valid && d_out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output actual=%0h required=none", c_out);
          end else begin
            e = sb.pop_front();
            chk("out", c_out, e.out);
            chk("flags", {c_zero, c_parity}, {e.zero, e.parity});
          end
        end
        prev_hold = c_out_valid && !d_out_ready;
        prev_out  = c_out;
        prev_z    = c_zero;
        prev_p    = c_parity;
      end
    end
  end

  initial begin
    bit acc;
    int accepted, ones, first, last;
    logic [127:0] x;

    rst = 1'b1;
    d_in_valid = 0; d_out_ready = 1; d_A = '0; d_B = '0; d_op = '0;
    #1;
    chk("reset_out_valid", c_out_valid, 0);
    chk("reset_out", c_out, 0);
    chk("reset_flags", {c_zero, c_parity}, 2'b10);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", c_in_ready, 1);

    // directed XNOR vector with two-cycle latency
    ovr = '{out: 128'h4444_6666_0000_6666, zero: 1'b0, parity: 1'b0};
    use_ovr = 1;
    drive(1'b1, 3'b011, 128'hAAAA_BBBB_CCCC_DDDD, 128'h1111_2222_3333_4444, 1'b1, acc);
    chk("lat_accept", acc, 1);
    idle(1'b1);
    chk("lat_cycle1_valid", c_out_valid, 0);
    idle(1'b1);
    chk("lat_cycle2_valid", c_out_valid, 1);
    drain();

    ovr = '{out: 128'h1, zero: 1'b0, parity: 1'b1};
    use_ovr = 1;
    drive(1'b1, 3'b011, 128'hFFFF_FFFF_FFFF_FFFF, 128'h1, 1'b1, acc);
    x = 128'(rnd128() & 128'hFFFF_FFFF_FFFF_FFFF);
    ovr = '{out: 128'h0, zero: 1'b1, parity: 1'b0};
    use_ovr = 1;
    drive(1'b1, 3'b010, x, x, 1'b1, acc);
    drain();

    // all eight ops back to back
    ones = 0; first = -1; last = -1;
    for (int i = 0; i < 12; i++) begin
      if (i < 8) begin
        drive(1'b1, 3'(i), rnd128(), rnd128(), 1'b1, acc);
        chk("stream_accept", acc, 1);
      end else begin
        idle(1'b1);
      end
      if (c_out_valid) begin
        ones++;
        if (first < 0) first = i;
        last = i;
      end
    end
    chk("stream_valid_count", 128'(ones), 128'd8);
    chk("stream_valid_span", 128'(last - first), 128'd7);
    drain();

    // backpressure: only two results can be buffered
    accepted = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'($urandom_range(7)), rnd128(), rnd128(), 1'b0, acc);
      if (acc) accepted++;
    end
    chk("bp_accepted", 128'(accepted), 128'd2);
    chk("bp_in_ready_low", c_in_ready, 0);
    drive(1'b1, 3'($urandom_range(7)), rnd128(), rnd128(), 1'b1, acc);
    chk("bp_release_ready", acc, 1);
    drain();

    // async reset with two results buffered
    drive(1'b1, 3'd1, rnd128(), rnd128(), 1'b0, acc);
    drive(1'b1, 3'd4, rnd128(), rnd128(), 1'b0, acc);
    @(negedge clk);
    d_in_valid = 0;
    #3;
    chk("pre_rst_full", {c_out_valid, c_in_ready}, 2'b10);
    rst = 1'b1;
    #1;
    chk("rst_out_valid", c_out_valid, 0);
    chk("rst_out", c_out, 0);
    chk("rst_flags", {c_zero, c_parity}, 2'b10);
    sb.delete();
    @(negedge clk);
    #3;
    rst = 1'b0;
    ones = 0;
    for (int i = 0; i < 6; i++) begin
      idle(1'b1);
      if (c_out_valid) ones++;
    end
    chk("rst_no_stale", 128'(ones), 128'd0);
    chk("rst_in_ready", c_in_ready, 1);

    // random regression on each width
    for (int g = 0; g < 3; g++) begin
      sel = g;
      cur_w = (g == 0) ? 64 : ((g == 1) ? 8 : 128);
      for (int i = 0; i < 300; i++) begin
        drive(($urandom % 4) != 0, 3'($urandom_range(7)), rnd128(), rnd128(),
              ($urandom % 3) != 0, acc);
      end
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
